// File: rtl/alu_op_issue_if.sv
// Operand/operation bundle between the ID-side producer and the EX-stage ALU.
// master = the issue block, slave = the surrounding pipeline (ID upstream, EX downstream).
interface alu_op_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     illegal;

  modport master (
    input  in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, flush, out_ready,
    output in_ready, out_valid, Operation, SrcA, SrcB, illegal
  );

  modport slave (
    output in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, flush, out_ready,
    input  in_ready, out_valid, Operation, SrcA, SrcB, illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// RV32I opcode/funct decode into ALU Operation/SrcA/SrcB, registered toward EX
// through a main + skid register pair so a stalled EX never costs a bubble.
module alu_op_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_issue_if.master     bus
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_TRUE = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic                     ill;
  } entry_t;

  // State encoding is literally {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_TWO   = 2'b11
  } state_t;

  state_t r_state;
  state_t w_state_next;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_dec;
  logic   w_f7_zero;
  logic   w_f7_alt;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_load_main;
  logic   w_load_skid;
  logic   w_skid_to_main;

  assign w_f7_zero = (bus.funct7 == 7'b0000000);
  assign w_f7_alt  = (bus.funct7 == 7'b0100000);

  always_comb begin
    w_dec.op  = OP_AND;
    w_dec.a   = bus.rs1_data;
    w_dec.b   = bus.rs2_data;
    w_dec.ill = 1'b0;
    case (bus.opcode)
      7'b0110011: begin
        case (bus.funct3)
          3'b000:  if (w_f7_zero) w_dec.op = OP_ADD; else if (w_f7_alt) w_dec.op = OP_SUB; else w_dec.ill = 1'b1;
          3'b101:  if (w_f7_zero) w_dec.op = OP_SRL; else if (w_f7_alt) w_dec.op = OP_SRA; else w_dec.ill = 1'b1;
          3'b111:  if (w_f7_zero) w_dec.op = OP_AND; else w_dec.ill = 1'b1;
          3'b110:  if (w_f7_zero) w_dec.op = OP_OR;  else w_dec.ill = 1'b1;
          3'b100:  if (w_f7_zero) w_dec.op = OP_XOR; else w_dec.ill = 1'b1;
          3'b001:  if (w_f7_zero) w_dec.op = OP_SLL; else w_dec.ill = 1'b1;
          3'b010:  if (w_f7_zero) w_dec.op = OP_SLT; else w_dec.ill = 1'b1;
          default: w_dec.ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_dec.b = bus.imm;
        case (bus.funct3)
          3'b000:  w_dec.op = OP_ADD;
          3'b111:  w_dec.op = OP_AND;
          3'b110:  w_dec.op = OP_OR;
          3'b100:  w_dec.op = OP_XOR;
          3'b010:  w_dec.op = OP_SLT;
          3'b001:  if (w_f7_zero) w_dec.op = OP_SLL; else w_dec.ill = 1'b1;
          3'b101:  if (w_f7_zero) w_dec.op = OP_SRL; else if (w_f7_alt) w_dec.op = OP_SRA; else w_dec.ill = 1'b1;
          default: w_dec.ill = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        w_dec.op = OP_ADD;
        w_dec.b  = bus.imm;
      end
      7'b1100011: begin
        case (bus.funct3)
          3'b000:  w_dec.op = OP_BEQ;
          3'b001:  w_dec.op = OP_BNE;
          3'b100:  w_dec.op = OP_BLT;
          3'b101:  w_dec.op = OP_BGE;
          default: w_dec.ill = 1'b1;
        endcase
      end
      7'b1101111, 7'b1100111: begin
        w_dec.op = OP_TRUE;
        w_dec.b  = bus.imm;
      end
      7'b0110111: begin
        w_dec.op = OP_ADD;
        w_dec.a  = '0;
        w_dec.b  = bus.imm;
      end
      default: w_dec.ill = 1'b1;
    endcase
    // Illegal ops still travel downstream, but with a canonical operand selection.
    if (w_dec.ill) begin
      w_dec.op = OP_AND;
      w_dec.a  = bus.rs1_data;
      w_dec.b  = bus.rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_next = S_ONE;
        S_ONE: begin
          if (w_accept && !bus.out_ready)      w_state_next = S_TWO;
          else if (!w_accept && bus.out_ready) w_state_next = S_EMPTY;
        end
        S_TWO:   if (bus.out_ready) w_state_next = S_ONE;
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_in_ready     = (r_state != S_TWO);
    w_out_valid    = r_state[1];
    w_accept       = bus.in_valid && w_in_ready;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (!bus.flush) begin
      case (r_state)
        S_EMPTY: w_load_main    = w_accept;
        S_ONE: begin
          w_load_main = w_accept && bus.out_ready;
          w_load_skid = w_accept && !bus.out_ready;
        end
        S_TWO:   w_skid_to_main = bus.out_ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main)         r_main <= w_dec;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_dec;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.Operation = r_main.op;
  assign bus.SrcA      = r_main.a;
  assign bus.SrcB      = r_main.b;
  assign bus.illegal   = r_main.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
// Table of decode vectors pushed through a scoreboard, plus hand sequences for
// back-pressure, flush and reset while ops are held.
module tb_alu_op_issue;
  logic clk;
  logic reset;

  alu_op_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eill;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [31:0] R1 = 32'h0000_000A;
  localparam logic [31:0] R2 = 32'h0000_0003;
  localparam logic [31:0] IM = 32'h0000_0FF4;

  task automatic addv(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic [3:0] eop, input logic [31:0] ea, input logic [31:0] eb,
                      input logic eill);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.eop = eop; v.ea = ea; v.eb = eb; v.eill = eill;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v);
    bit accepted;
    exp_t e;
    accepted     = 1'b0;
    bus.opcode   = v.opc;
    bus.funct3   = v.f3;
    bus.funct7   = v.f7;
    bus.rs1_data = v.rs1;
    bus.rs2_data = v.rs2;
    bus.imm      = v.imm;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 && !bus.flush) begin
        e.op = v.eop; e.a = v.ea; e.b = v.eb; e.ill = v.eill;
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  // Scoreboard side: every handshake on the output pops one expected op.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL out_unexpected actual=op%h a=%h b=%h ill=%b required=no_output",
                 bus.Operation, bus.SrcA, bus.SrcB, bus.illegal);
      end else begin
        e = sb.pop_front();
        if (bus.Operation !== e.op || bus.SrcA !== e.a || bus.SrcB !== e.b || bus.illegal !== e.ill) begin
          n_mis++;
          $display("FAIL out_txn actual=op%h a=%h b=%h ill=%b required=op%h a=%h b=%h ill=%b",
                   bus.Operation, bus.SrcA, bus.SrcB, bus.illegal, e.op, e.a, e.b, e.ill);
        end else begin
          $display("out op=%h a=%h b=%h ill=%b", bus.Operation, bus.SrcA, bus.SrcB, bus.illegal);
        end
      end
    end
  end

  task automatic drain(input string name);
    repeat (6) @(posedge clk);
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // R-type
    addv(7'b0110011, 3'b000, 7'b0100000, R1, R2, IM, 4'b0110, R1, R2, 1'b0); // SUB
    addv(7'b0110011, 3'b000, 7'b0000000, R1, R2, IM, 4'b0010, R1, R2, 1'b0); // ADD
    addv(7'b0110011, 3'b111, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b0); // AND
    addv(7'b0110011, 3'b110, 7'b0000000, R1, R2, IM, 4'b0001, R1, R2, 1'b0); // OR
    addv(7'b0110011, 3'b100, 7'b0000000, R1, R2, IM, 4'b0011, R1, R2, 1'b0); // XOR
    addv(7'b0110011, 3'b001, 7'b0000000, R1, R2, IM, 4'b0100, R1, R2, 1'b0); // SLL
    addv(7'b0110011, 3'b101, 7'b0000000, R1, R2, IM, 4'b0101, R1, R2, 1'b0); // SRL
    addv(7'b0110011, 3'b101, 7'b0100000, R1, R2, IM, 4'b0111, R1, R2, 1'b0); // SRA
    addv(7'b0110011, 3'b010, 7'b0000000, R1, R2, IM, 4'b1100, R1, R2, 1'b0); // SLT
    addv(7'b0110011, 3'b000, 7'b0000001, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // bad f7
    addv(7'b0110011, 3'b111, 7'b0100000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // AND alt f7
    addv(7'b0110011, 3'b011, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // f3 011
    // I-type ALU
    addv(7'b0010011, 3'b000, 7'b0101010, R1, R2, IM, 4'b0010, R1, IM, 1'b0); // ADDI
    addv(7'b0010011, 3'b111, 7'b1111111, R1, R2, IM, 4'b0000, R1, IM, 1'b0); // ANDI
    addv(7'b0010011, 3'b110, 7'b0000000, R1, R2, IM, 4'b0001, R1, IM, 1'b0); // ORI
    addv(7'b0010011, 3'b100, 7'b0000000, R1, R2, IM, 4'b0011, R1, IM, 1'b0); // XORI
    addv(7'b0010011, 3'b010, 7'b0000000, R1, R2, IM, 4'b1100, R1, IM, 1'b0); // SLTI
    addv(7'b0010011, 3'b001, 7'b0000000, R1, R2, IM, 4'b0100, R1, IM, 1'b0); // SLLI
    addv(7'b0010011, 3'b001, 7'b0100000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // SLLI bad f7
    addv(7'b0010011, 3'b101, 7'b0000000, R1, R2, IM, 4'b0101, R1, IM, 1'b0); // SRLI
    addv(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, R2, 32'd4, 4'b0111, 32'h8000_0000, 32'd4, 1'b0); // SRAI
    addv(7'b0010011, 3'b011, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // SLTIU
    // load/store, branch, jumps, LUI, misc
    addv(7'b0000011, 3'b010, 7'b0000000, R1, R2, IM, 4'b0010, R1, IM, 1'b0); // LW
    addv(7'b0100011, 3'b010, 7'b0000000, R1, R2, IM, 4'b0010, R1, IM, 1'b0); // SW
    addv(7'b1100011, 3'b000, 7'b0000000, R1, R2, IM, 4'b1000, R1, R2, 1'b0); // BEQ
    addv(7'b1100011, 3'b001, 7'b0000000, R1, R2, IM, 4'b1011, R1, R2, 1'b0); // BNE
    addv(7'b1100011, 3'b100, 7'b0000000, R1, R2, IM, 4'b1001, R1, R2, 1'b0); // BLT
    addv(7'b1100011, 3'b101, 7'b0000000, R1, R2, IM, 4'b1010, R1, R2, 1'b0); // BGE
    addv(7'b1100011, 3'b010, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // branch 010
    addv(7'b1100011, 3'b111, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // branch 111
    addv(7'b1101111, 3'b000, 7'b0000000, R1, R2, IM, 4'b1111, R1, IM, 1'b0); // JAL
    addv(7'b1100111, 3'b000, 7'b0000000, R1, R2, IM, 4'b1111, R1, IM, 1'b0); // JALR
    addv(7'b0110111, 3'b000, 7'b0000000, R1, R2, 32'h1234_5000, 4'b0010, 32'd0, 32'h1234_5000, 1'b0); // LUI
    addv(7'b1111111, 3'b000, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // illegal opcode
    addv(7'b0010111, 3'b000, 7'b0000000, R1, R2, IM, 4'b0000, R1, R2, 1'b1); // AUIPC unsupported

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7 = 7'b0000000;
    bus.rs1_data = 32'h5555_5555; bus.rs2_data = 32'h6666_6666; bus.imm = 32'h7777_7777;
    bus.in_valid = 1'b1; // ignored while reset is high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_operation", 32'(bus.Operation), 32'd0);
    chk("rst_srca",      bus.SrcA,           32'd0);
    chk("rst_srcb",      bus.SrcB,           32'd0);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;

    // Full decode table, back-to-back with EX always ready.
    bus.out_ready = 1'b1;
    foreach (vecs[k]) send(vecs[k]);
    drain("drain_table");

    // Back-pressure: two ops fill main+skid, third waits until EX drains.
    bus.out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[12]);
    @(negedge clk);
    chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_op",   32'(bus.Operation), 32'(vecs[0].eop));
      chk("bp_hold_srcb", bus.SrcB,           vecs[0].eb);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(vecs[20]);
    drain("drain_bp");

    // Flush while full with a new op offered in the same cycle.
    bus.out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    bus.opcode = vecs[5].opc; bus.funct3 = vecs[5].f3; bus.funct7 = vecs[5].f7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_emit", 32'(bus.out_valid), 32'd0);
    end

    // Flush in ONE with EX taking the held op that same cycle.
    @(posedge clk); #1;
    send(vecs[6]);
    bus.opcode = vecs[7].opc; bus.funct3 = vecs[7].f3; bus.funct7 = vecs[7].f7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_fire_counted", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("flush2_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset while two ops are held.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(vecs[8]);
    send(vecs[9]);
    reset = 1'b1;
    bus.opcode = vecs[10].opc; bus.funct3 = vecs[10].f3; bus.funct7 = vecs[10].f7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_operation", 32'(bus.Operation), 32'd0);
    chk("midrst_srca",      bus.SrcA,           32'd0);
    chk("midrst_srcb",      bus.SrcB,           32'd0);
    chk("midrst_illegal",   32'(bus.illegal),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",   32'(bus.in_ready),  32'd1);
    chk("midrst_out_valid2", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(vecs[32]);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
